// File: rtl/bullet_arbiter.sv
// bullet_arbiter
// Shares a small pool of bullet slots between two players. The block turns
// fire-button edges into pending requests and applies per-player cooldown
// and live-bullet limits. It offers one spawn at a time to the bullet
// datapath through a valid/ready handshake.
module bullet_arbiter #(
    parameter int NUM_SLOTS      = 4,
    parameter int MAX_PER_PLAYER = 2,
    parameter int COOLDOWN       = 30,
    localparam int SLOT_W        = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic                 flush_i,
    input  logic                 frame_tick_i,
    input  logic                 fire_p1_i,
    input  logic                 fire_p2_i,
    input  logic [NUM_SLOTS-1:0] slot_free_i,
    input  logic                 spawn_ready_i,
    output logic                 spawn_valid_o,
    output logic                 spawn_player_o,
    output logic [SLOT_W-1:0]    spawn_slot_o,
    output logic [NUM_SLOTS-1:0] slot_busy_o,
    output logic [NUM_SLOTS-1:0] slot_owner_o,
    output logic [2:0]           active_p1_o,
    output logic [2:0]           active_p2_o
);

    localparam logic [7:0] COOLDOWN_LD = 8'(COOLDOWN);
    localparam logic [2:0] MAX_CNT     = 3'(MAX_PER_PLAYER);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t state, state_nxt;

    // Cooldown counters saturate at zero instead of wrapping.
    function automatic logic [7:0] cd_dec(input logic [7:0] cd);
        return (cd == 8'd0) ? 8'd0 : cd - 8'd1;
    endfunction

    // Population count of a slot mask (retire pulses belonging to one owner).
    function automatic logic [2:0] pop_cnt(input logic [NUM_SLOTS-1:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            c = c + {2'b00, v[k]};
        end
        return c;
    endfunction

    // Live-count update: retirements and an accept can land in the same cycle.
    function automatic logic [2:0] cnt_next(input logic [2:0] cnt,
                                            input logic [2:0] dec,
                                            input logic       inc);
        return cnt - dec + {2'b00, inc};
    endfunction

    logic                 armed;
    logic                 fire_prev_p1, fire_prev_p2;
    logic                 edge_p1, edge_p2;
    logic                 pending_p1, pending_p2;
    logic [7:0]           cooldown_p1, cooldown_p2;
    logic [NUM_SLOTS-1:0] busy, owner;
    logic [2:0]           active_p1, active_p2;
    logic                 last_grant;      // 0 = player 1, 1 = player 2
    logic                 offer_player;
    logic [SLOT_W-1:0]    offer_slot;

    logic                 accept, accept_p1, accept_p2;
    logic                 any_free;
    logic [SLOT_W-1:0]    free_slot;
    logic                 elig_p1, elig_p2, grant_req, winner, grant_load;
    logic [NUM_SLOTS-1:0] freed, slot_onehot;
    logic [2:0]           freed_p1, freed_p2;

    // An edge needs one clean cycle after reset, so a button already held at
    // reset release does not look like a press.
    assign edge_p1 = armed & fire_p1_i & ~fire_prev_p1;
    assign edge_p2 = armed & fire_p2_i & ~fire_prev_p2;

    assign accept    = (state == OFFER) & spawn_ready_i;
    assign accept_p1 = accept & ~offer_player;
    assign accept_p2 = accept & offer_player;

    assign any_free = ~(&busy);

    // Lowest-index free slot; only meaningful when any_free is set.
    always_comb begin
        free_slot = '0;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (!busy[k]) begin
                free_slot = SLOT_W'(k);
            end
        end
    end

    // Eligibility and round-robin choice of the winner on a tie.
    always_comb begin
        elig_p1    = pending_p1 & (cooldown_p1 == 8'd0) & (active_p1 < MAX_CNT) & any_free;
        elig_p2    = pending_p2 & (cooldown_p2 == 8'd0) & (active_p2 < MAX_CNT) & any_free;
        grant_req  = elig_p1 | elig_p2;
        winner     = (elig_p1 & elig_p2) ? ~last_grant : elig_p2;
        grant_load = (state == IDLE) & grant_req & ~flush_i;
    end

    // Retire pulses only count against slots that are actually live.
    always_comb begin
        freed       = slot_free_i & busy;
        freed_p1    = pop_cnt(freed & ~owner);
        freed_p2    = pop_cnt(freed & owner);
        slot_onehot = NUM_SLOTS'(1) << offer_slot;
    end

    // Registered fire levels for edge detection.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            armed        <= 1'b0;
            fire_prev_p1 <= 1'b0;
            fire_prev_p2 <= 1'b0;
        end else begin
            armed        <= 1'b1;
            fire_prev_p1 <= fire_p1_i;
            fire_prev_p2 <= fire_p2_i;
        end
    end

    // Pending requests: one outstanding per player, dropped while disabled.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pending_p1 <= 1'b0;
            pending_p2 <= 1'b0;
        end else if (flush_i || !enable_i) begin
            pending_p1 <= 1'b0;
            pending_p2 <= 1'b0;
        end else begin
            if (accept_p1) begin
                pending_p1 <= 1'b0;
            end else if (edge_p1) begin
                pending_p1 <= 1'b1;
            end
            if (accept_p2) begin
                pending_p2 <= 1'b0;
            end else if (edge_p2) begin
                pending_p2 <= 1'b1;
            end
        end
    end

    // Per-player cooldown: reload on grant, count down on frame ticks.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cooldown_p1 <= 8'd0;
            cooldown_p2 <= 8'd0;
        end else if (flush_i) begin
            cooldown_p1 <= 8'd0;
            cooldown_p2 <= 8'd0;
        end else begin
            if (accept_p1) begin
                cooldown_p1 <= COOLDOWN_LD;
            end else if (frame_tick_i) begin
                cooldown_p1 <= cd_dec(cooldown_p1);
            end
            if (accept_p2) begin
                cooldown_p2 <= COOLDOWN_LD;
            end else if (frame_tick_i) begin
                cooldown_p2 <= cd_dec(cooldown_p2);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: offer when someone is eligible, return once accepted.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_req) state_nxt = OFFER;
            OFFER:   if (accept)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush_i) begin
            state_nxt = IDLE;
        end
    end

    // FSM outputs: the offer is valid for the whole OFFER state.
    always_comb begin
        spawn_valid_o  = (state == OFFER);
        spawn_player_o = offer_player;
        spawn_slot_o   = offer_slot;
    end

    // Offer contents are captured on entry to OFFER and held until accepted.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            offer_player <= 1'b0;
            offer_slot   <= '0;
        end else if (flush_i) begin
            offer_player <= 1'b0;
            offer_slot   <= '0;
        end else if (grant_load) begin
            offer_player <= winner;
            offer_slot   <= free_slot;
        end
    end

    // Slot map and live counts; a retire and an accept can coincide.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            busy      <= '0;
            owner     <= '0;
            active_p1 <= 3'd0;
            active_p2 <= 3'd0;
        end else if (flush_i) begin
            busy      <= '0;
            owner     <= '0;
            active_p1 <= 3'd0;
            active_p2 <= 3'd0;
        end else begin
            busy      <= (busy & ~freed) | (accept ? slot_onehot : '0);
            if (accept) begin
                owner <= (owner & ~slot_onehot) | (offer_player ? slot_onehot : '0);
            end
            active_p1 <= cnt_next(active_p1, freed_p1, accept_p1);
            active_p2 <= cnt_next(active_p2, freed_p2, accept_p2);
        end
    end

    // Round-robin pointer; defaults to player 2 so player 1 wins the first tie.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            last_grant <= 1'b1;
        end else if (flush_i) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= offer_player;
        end
    end

    assign slot_busy_o  = busy;
    assign slot_owner_o = owner;
    assign active_p1_o  = active_p1;
    assign active_p2_o  = active_p2;

endmodule

// File: tb/tb_bullet_arbiter.sv
// tb_bullet_arbiter
// Directed scenarios plus a randomized run, all outputs compared every cycle
// against a slot-pool reference model kept in this bench.
module tb_bullet_arbiter;

    localparam int NS   = 4;
    localparam int MAXP = 2;
    localparam int CD   = 30;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b0;
    logic          enable_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          frame_tick_i = 1'b0;
    logic          fire_p1_i = 1'b0;
    logic          fire_p2_i = 1'b0;
    logic [NS-1:0] slot_free_i = '0;
    logic          spawn_ready_i = 1'b0;
    logic          spawn_valid_o;
    logic          spawn_player_o;
    logic [1:0]    spawn_slot_o;
    logic [NS-1:0] slot_busy_o;
    logic [NS-1:0] slot_owner_o;
    logic [2:0]    active_p1_o;
    logic [2:0]    active_p2_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a slot pool with owners; counts are derived from it.
    int m_busy[NS];
    int m_own[NS];
    int m_pend[2];
    int m_cd[2];
    int m_prev[2];
    int m_valid, m_player, m_slot, m_last, m_armed;

    always #5 clk_i = ~clk_i;

    bullet_arbiter #(
        .NUM_SLOTS(NS),
        .MAX_PER_PLAYER(MAXP),
        .COOLDOWN(CD)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .enable_i(enable_i),
        .flush_i(flush_i),
        .frame_tick_i(frame_tick_i),
        .fire_p1_i(fire_p1_i),
        .fire_p2_i(fire_p2_i),
        .slot_free_i(slot_free_i),
        .spawn_ready_i(spawn_ready_i),
        .spawn_valid_o(spawn_valid_o),
        .spawn_player_o(spawn_player_o),
        .spawn_slot_o(spawn_slot_o),
        .slot_busy_o(slot_busy_o),
        .slot_owner_o(slot_owner_o),
        .active_p1_o(active_p1_o),
        .active_p2_o(active_p2_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_cnt(input int p);
        int c = 0;
        for (int k = 0; k < NS; k++) begin
            if (m_busy[k] != 0 && m_own[k] == p) c++;
        end
        return c;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NS; k++) begin
            m_busy[k] = 0;
            m_own[k]  = 0;
        end
        for (int p = 0; p < 2; p++) begin
            m_pend[p] = 0;
            m_cd[p]   = 0;
        end
        m_valid  = 0;
        m_player = 0;
        m_slot   = 0;
        m_last   = 1;
    endtask

    task automatic model_reset();
        model_clear();
        m_prev[0] = 0;
        m_prev[1] = 0;
        m_armed   = 0;
    endtask

    // One clock edge of the specified behaviour, using the inputs of the cycle.
    task automatic model_step();
        int fr[2];
        int e[2];
        int el[2];
        int acc, lf, anyf;
        fr[0] = int'(fire_p1_i);
        fr[1] = int'(fire_p2_i);
        if (!reset_i) begin
            model_reset();
            return;
        end
        if (flush_i) begin
            model_clear();
        end else begin
            acc  = (m_valid != 0 && spawn_ready_i) ? 1 : 0;
            anyf = 0;
            lf   = 0;
            for (int k = NS - 1; k >= 0; k--) begin
                if (m_busy[k] == 0) begin
                    anyf = 1;
                    lf   = k;
                end
            end
            for (int p = 0; p < 2; p++) begin
                e[p]  = (m_armed != 0 && fr[p] != 0 && m_prev[p] == 0) ? 1 : 0;
                el[p] = (m_pend[p] != 0 && m_cd[p] == 0 && m_cnt(p) < MAXP && anyf != 0) ? 1 : 0;
            end
            for (int k = 0; k < NS; k++) begin
                if (slot_free_i[k] && m_busy[k] != 0) m_busy[k] = 0;
            end
            if (acc != 0) begin
                m_busy[m_slot] = 1;
                m_own[m_slot]  = m_player;
            end
            for (int p = 0; p < 2; p++) begin
                if (acc != 0 && m_player == p) m_cd[p] = CD;
                else if (frame_tick_i && m_cd[p] > 0) m_cd[p] = m_cd[p] - 1;
                if (!enable_i) m_pend[p] = 0;
                else if (acc != 0 && m_player == p) m_pend[p] = 0;
                else if (e[p] != 0) m_pend[p] = 1;
            end
            if (m_valid != 0) begin
                if (acc != 0) begin
                    m_valid = 0;
                    m_last  = m_player;
                end
            end else if (el[0] != 0 || el[1] != 0) begin
                if (el[0] != 0 && el[1] != 0) m_player = (m_last == 1) ? 0 : 1;
                else m_player = (el[0] != 0) ? 0 : 1;
                m_slot  = lf;
                m_valid = 1;
            end
        end
        m_prev[0] = fr[0];
        m_prev[1] = fr[1];
        m_armed   = 1;
    endtask

    task automatic compare_all();
        logic [NS-1:0] eb, eo;
        for (int k = 0; k < NS; k++) begin
            eb[k] = (m_busy[k] != 0);
            eo[k] = (m_busy[k] != 0 && m_own[k] == 1);
        end
        chk("valid", 32'(spawn_valid_o), 32'(m_valid));
        if (m_valid != 0) begin
            chk("player", 32'(spawn_player_o), 32'(m_player));
            chk("slot", 32'(spawn_slot_o), 32'(m_slot));
        end
        chk("busy", 32'(slot_busy_o), 32'(eb));
        chk("owner", 32'(slot_owner_o & slot_busy_o), 32'(eo));
        chk("active_p1", 32'(active_p1_o), 32'(m_cnt(0)));
        chk("active_p2", 32'(active_p2_o), 32'(m_cnt(1)));
    endtask

    task automatic step();
        @(posedge clk_i);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic fire_edge(input logic a, input logic b);
        fire_p1_i = a;
        fire_p2_i = b;
        step();
        fire_p1_i = 1'b0;
        fire_p2_i = 1'b0;
    endtask

    // Enough frame ticks to let any cooldown reach zero.
    task automatic expire();
        for (int i = 0; i < CD + 1; i++) begin
            frame_tick_i = 1'b1;
            step();
            frame_tick_i = 1'b0;
            step();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(spawn_valid_o), 32'd0);
        chk({tag, "_player"}, 32'(spawn_player_o), 32'd0);
        chk({tag, "_slot"}, 32'(spawn_slot_o), 32'd0);
        chk({tag, "_busy"}, 32'(slot_busy_o), 32'd0);
        chk({tag, "_owner"}, 32'(slot_owner_o), 32'd0);
        chk({tag, "_a1"}, 32'(active_p1_o), 32'd0);
        chk({tag, "_a2"}, 32'(active_p2_o), 32'd0);
    endtask

    task automatic do_reset();
        enable_i = 1'b0; flush_i = 1'b0; frame_tick_i = 1'b0;
        fire_p1_i = 1'b0; fire_p2_i = 1'b0; slot_free_i = '0; spawn_ready_i = 1'b0;
        reset_i = 1'b0;
        model_reset();
        step();
        step();
        check_reset_outputs("rst");
        reset_i = 1'b1;
        step();
    endtask

    initial begin
        model_reset();

        // Basic grant with ready held high.
        do_reset();
        enable_i = 1'b1; spawn_ready_i = 1'b1;
        step(); step();
        fire_edge(1'b1, 1'b0);
        chk("g_n1_valid", 32'(spawn_valid_o), 32'd0);
        step();
        chk("g_n2_valid", 32'(spawn_valid_o), 32'd1);
        chk("g_n2_player", 32'(spawn_player_o), 32'd0);
        chk("g_n2_slot", 32'(spawn_slot_o), 32'd0);
        step();
        chk("g_acc_valid", 32'(spawn_valid_o), 32'd0);
        chk("g_acc_busy", 32'(slot_busy_o), 32'b0001);
        chk("g_acc_a1", 32'(active_p1_o), 32'd1);

        // Tie from reset, then round-robin after player 1 was last granted.
        do_reset();
        enable_i = 1'b1; spawn_ready_i = 1'b1;
        fire_edge(1'b1, 1'b1);
        step();
        chk("tie_p1", 32'({spawn_valid_o, spawn_player_o, spawn_slot_o}), 32'b1000);
        step();
        chk("tie_gap", 32'(spawn_valid_o), 32'd0);
        step();
        chk("tie_p2", 32'({spawn_valid_o, spawn_player_o, spawn_slot_o}), 32'b1101);
        step();
        expire();
        slot_free_i = 4'b0011;
        step();
        slot_free_i = '0;
        chk("tie_freed", 32'(slot_busy_o), 32'd0);
        fire_edge(1'b1, 1'b0);
        step();
        chk("solo_p1", 32'({spawn_valid_o, spawn_player_o}), 32'b10);
        step();
        expire();
        fire_edge(1'b1, 1'b1);
        step();
        chk("tie2_p2", 32'({spawn_valid_o, spawn_player_o, spawn_slot_o}), 32'b1101);
        step(); step(); step();

        // Per-player limit and full pool.
        do_reset();
        enable_i = 1'b1; spawn_ready_i = 1'b1;
        fire_edge(1'b1, 1'b0); step(); step(); expire();
        fire_edge(1'b1, 1'b0); step(); step(); expire();
        chk("lim_a1", 32'(active_p1_o), 32'd2);
        fire_edge(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("lim_p1_max", 32'(spawn_valid_o), 32'd0);
        end
        fire_edge(1'b0, 1'b1); step();
        chk("lim_s2", 32'({spawn_player_o, spawn_slot_o}), 32'b110);
        step(); expire();
        fire_edge(1'b0, 1'b1); step();
        chk("lim_s3", 32'({spawn_player_o, spawn_slot_o}), 32'b111);
        step();
        chk("lim_full", 32'(slot_busy_o), 32'b1111);
        expire();
        fire_edge(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("lim_full_nooffer", 32'(spawn_valid_o), 32'd0);
        end
        slot_free_i = 4'b0010;
        step();
        slot_free_i = '0;
        step();
        chk("lim_refill", 32'({spawn_valid_o, spawn_player_o, spawn_slot_o}), 32'b1001);
        step();

        // Cooldown: re-fire after 10 ticks, offer 2 cycles after 20 more ticks.
        do_reset();
        enable_i = 1'b1; spawn_ready_i = 1'b1;
        fire_edge(1'b1, 1'b0); step(); step();
        for (int i = 0; i < 10; i++) begin
            frame_tick_i = 1'b1; step(); frame_tick_i = 1'b0; step();
        end
        fire_edge(1'b1, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            frame_tick_i = 1'b1;
            step();
            frame_tick_i = 1'b0;
            chk("cd_hold", 32'(spawn_valid_o), 32'd0);
            if (i < 20) step();
        end
        step();
        chk("cd_offer", 32'({spawn_valid_o, spawn_player_o, spawn_slot_o}), 32'b1001);

        // Backpressure, enable drop during offer, flush, async reset.
        do_reset();
        enable_i = 1'b1; spawn_ready_i = 1'b1;
        fire_edge(1'b1, 1'b0); step(); step();
        spawn_ready_i = 1'b0;
        fire_edge(1'b0, 1'b1); step();
        for (int i = 0; i < 50; i++) begin
            enable_i = (i >= 20 && i < 30) ? 1'b0 : 1'b1;
            step();
            chk("bp_stable", 32'({spawn_valid_o, spawn_player_o, spawn_slot_o}), 32'b1101);
        end
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("fl_valid", 32'(spawn_valid_o), 32'd0);
        chk("fl_busy", 32'(slot_busy_o), 32'd0);
        chk("fl_cnt", 32'({active_p1_o, active_p2_o}), 32'd0);
        fire_edge(1'b1, 1'b0); step();
        chk("pre_rst_offer", 32'(spawn_valid_o), 32'd1);
        #2;
        reset_i = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("async");
        fire_p1_i = 1'b1;
        step(); step();
        reset_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rel_no_spurious", 32'(spawn_valid_o), 32'd0);
        end
        fire_p1_i = 1'b0;

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            enable_i      = ($urandom_range(0, 15) != 0);
            flush_i       = ($urandom_range(0, 149) == 0);
            frame_tick_i  = ($urandom_range(0, 3) == 0);
            fire_p1_i     = ($urandom_range(0, 2) == 0);
            fire_p2_i     = ($urandom_range(0, 2) == 0);
            spawn_ready_i = ($urandom_range(0, 1) == 0);
            for (int k = 0; k < NS; k++) slot_free_i[k] = ($urandom_range(0, 11) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
